// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and ID/EX record types for the MIPS pipeline.
// Opcode constants, ALU operation encodings, decoded-control record,
// ID/EX pipeline-register record and the immediate-extension helper.
package mips_pkg;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // ALU operation requested from the execute stage
  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_SLT   = 3'b101
  } alu_op_e;

  // Decoded control for one instruction
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch;
    logic    branch_ne;
    alu_op_e alu_op;
    logic    zero_ext;   // immediate is zero- rather than sign-extended
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(12'd0);

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        branch;
    logic        branch_ne;
  } idex_t;

  // Widen a 16-bit immediate to 32 bits by zero or sign extension
  function automatic logic [31:0] extend_imm(input logic [15:0] imm,
                                             input logic        zero_ext);
    logic [31:0] res;
    if (zero_ext) begin
      res = {16'h0000, imm};
    end else begin
      res = {{16{imm[15]}}, imm};
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two combinational read ports, one write port.
// $0 reads as zero and ignores writes. Reset clears every register.
// Optional macro WB_BYPASS_EN: a read of the register being written in the
// same cycle returns the incoming write data instead of the stored value.
module reg_file (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  // Storage: synchronous clear on reset, otherwise commit write-back (never to $0)
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end else begin
      regs_q[waddr_i] <= regs_q[waddr_i];
    end
  end

  // Read port A: $0 hardwired to zero, optional same-cycle write forwarding
  always_comb begin
    rdata_a_o = 32'd0;
    if (raddr_a_i == 5'd0) begin
      rdata_a_o = 32'd0;
`ifdef WB_BYPASS_EN
    end else if (we_i && (raddr_a_i == waddr_i)) begin
      rdata_a_o = wdata_i;
`endif
    end else begin
      rdata_a_o = regs_q[raddr_a_i];
    end
  end

  // Read port B: same rules as port A
  always_comb begin
    rdata_b_o = 32'd0;
    if (raddr_b_i == 5'd0) begin
      rdata_b_o = 32'd0;
`ifdef WB_BYPASS_EN
    end else if (we_i && (raddr_b_i == waddr_i)) begin
      rdata_b_o = wdata_i;
`endif
    end else begin
      rdata_b_o = regs_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS instruction-decode stage with the ID/EX pipeline register.
// Decodes the opcode into control, reads the register file, extends the
// immediate and registers everything for execute. FLUSH loads a bubble;
// unknown opcodes keep their data fields but carry no control.
// Optional macro WB_BYPASS_EN (handled inside reg_file): same-cycle
// write-back forwarding to the register reads.
module id_stage
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] CUR_INS,
  input  logic [31:0] NEXT_INS_ADR,
  input  logic        FLUSH,
  input  logic        WB_REG_WRITE,
  input  logic [4:0]  WB_WRITE_REG,
  input  logic [31:0] WB_WRITE_DATA,
  output logic [31:0] EX_PC4,
  output logic [31:0] EX_RS_DATA,
  output logic [31:0] EX_RT_DATA,
  output logic [31:0] EX_IMM,
  output logic [4:0]  EX_RT,
  output logic [4:0]  EX_RD,
  output logic [2:0]  EX_ALU_OP,
  output logic        EX_REG_DST,
  output logic        EX_ALU_SRC,
  output logic        EX_MEM_READ,
  output logic        EX_MEM_WRITE,
  output logic        EX_MEM_TO_REG,
  output logic        EX_REG_WRITE,
  output logic        EX_BRANCH,
  output logic        EX_BRANCH_NE
);

  logic [5:0]  opcode_s;
  logic [31:0] rs_data_s;
  logic [31:0] rt_data_s;
  ctrl_t       ctrl_s;
  idex_t       idex_d;
  idex_t       idex_q;

  assign opcode_s = CUR_INS[31:26];

  reg_file u_reg_file (
    .clk_i     (CLK),
    .rst_n_i   (RST_N),
    .raddr_a_i (CUR_INS[25:21]),
    .raddr_b_i (CUR_INS[20:16]),
    .rdata_a_o (rs_data_s),
    .rdata_b_o (rt_data_s),
    .we_i      (WB_REG_WRITE),
    .waddr_i   (WB_WRITE_REG),
    .wdata_i   (WB_WRITE_DATA)
  );

  // Opcode decode: unsupported opcodes fall through to an all-zero control word
  always_comb begin
    ctrl_s = CTRL_BUBBLE;
    case (opcode_s)
      OP_RTYPE: begin
        ctrl_s.reg_dst   = 1'b1;
        ctrl_s.alu_op    = ALU_FUNCT;
        ctrl_s.reg_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.reg_write = 1'b1;
      end
      OP_ANDI: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_AND;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.zero_ext  = 1'b1;
      end
      OP_ORI: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_OR;
        ctrl_s.reg_write = 1'b1;
        ctrl_s.zero_ext  = 1'b1;
      end
      OP_SLTI: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_SLT;
        ctrl_s.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl_s.alu_src    = 1'b1;
        ctrl_s.alu_op     = ALU_ADD;
        ctrl_s.mem_read   = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_s.alu_src   = 1'b1;
        ctrl_s.alu_op    = ALU_ADD;
        ctrl_s.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_s.alu_op = ALU_SUB;
        ctrl_s.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl_s.alu_op    = ALU_SUB;
        ctrl_s.branch_ne = 1'b1;
      end
      default: begin
        ctrl_s = CTRL_BUBBLE;
      end
    endcase
  end

  // ID/EX next state: a flush squashes everything, otherwise latch decode results
  always_comb begin
    idex_d = '0;
    if (FLUSH) begin
      idex_d = '0;
    end else begin
      idex_d.pc4        = NEXT_INS_ADR;
      idex_d.rs_data    = rs_data_s;
      idex_d.rt_data    = rt_data_s;
      idex_d.imm        = extend_imm(CUR_INS[15:0], ctrl_s.zero_ext);
      idex_d.rt         = CUR_INS[20:16];
      idex_d.rd         = CUR_INS[15:11];
      idex_d.alu_op     = ctrl_s.alu_op;
      idex_d.reg_dst    = ctrl_s.reg_dst;
      idex_d.alu_src    = ctrl_s.alu_src;
      idex_d.mem_read   = ctrl_s.mem_read;
      idex_d.mem_write  = ctrl_s.mem_write;
      idex_d.mem_to_reg = ctrl_s.mem_to_reg;
      idex_d.reg_write  = ctrl_s.reg_write;
      idex_d.branch     = ctrl_s.branch;
      idex_d.branch_ne  = ctrl_s.branch_ne;
    end
  end

  // ID/EX pipeline register: reset wins over everything, no stall
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign EX_PC4        = idex_q.pc4;
  assign EX_RS_DATA    = idex_q.rs_data;
  assign EX_RT_DATA    = idex_q.rt_data;
  assign EX_IMM        = idex_q.imm;
  assign EX_RT         = idex_q.rt;
  assign EX_RD         = idex_q.rd;
  assign EX_ALU_OP     = idex_q.alu_op;
  assign EX_REG_DST    = idex_q.reg_dst;
  assign EX_ALU_SRC    = idex_q.alu_src;
  assign EX_MEM_READ   = idex_q.mem_read;
  assign EX_MEM_WRITE  = idex_q.mem_write;
  assign EX_MEM_TO_REG = idex_q.mem_to_reg;
  assign EX_REG_WRITE  = idex_q.reg_write;
  assign EX_BRANCH     = idex_q.branch;
  assign EX_BRANCH_NE  = idex_q.branch_ne;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table followed by randomized traffic checked
// against a behavioural model of the decode stage and register file.
module tb_id_stage;

  // Expected/actual ID/EX contents; ctl = {reg_dst, alu_src, mem_read,
  // mem_write, mem_to_reg, reg_write, branch, branch_ne}
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs;
    logic [31:0] rtd;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [2:0]  aluop;
    logic [7:0]  ctl;
  } ex_t;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] ins;
    logic [31:0] pc4;
    ex_t         exp;
  } vec_t;

  localparam logic [7:0] C_R   = 8'b1000_0100;
  localparam logic [7:0] C_I   = 8'b0100_0100;
  localparam logic [7:0] C_LW  = 8'b0110_1100;
  localparam logic [7:0] C_SW  = 8'b0101_0000;
  localparam logic [7:0] C_BEQ = 8'b0000_0010;
  localparam logic [7:0] C_BNE = 8'b0000_0001;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] CUR_INS;
  logic [31:0] NEXT_INS_ADR;
  logic        FLUSH;
  logic        WB_REG_WRITE;
  logic [4:0]  WB_WRITE_REG;
  logic [31:0] WB_WRITE_DATA;
  logic [31:0] EX_PC4, EX_RS_DATA, EX_RT_DATA, EX_IMM;
  logic [4:0]  EX_RT, EX_RD;
  logic [2:0]  EX_ALU_OP;
  logic        EX_REG_DST, EX_ALU_SRC, EX_MEM_READ, EX_MEM_WRITE;
  logic        EX_MEM_TO_REG, EX_REG_WRITE, EX_BRANCH, EX_BRANCH_NE;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_regs [32];

  id_stage dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .CUR_INS       (CUR_INS),
    .NEXT_INS_ADR  (NEXT_INS_ADR),
    .FLUSH         (FLUSH),
    .WB_REG_WRITE  (WB_REG_WRITE),
    .WB_WRITE_REG  (WB_WRITE_REG),
    .WB_WRITE_DATA (WB_WRITE_DATA),
    .EX_PC4        (EX_PC4),
    .EX_RS_DATA    (EX_RS_DATA),
    .EX_RT_DATA    (EX_RT_DATA),
    .EX_IMM        (EX_IMM),
    .EX_RT         (EX_RT),
    .EX_RD         (EX_RD),
    .EX_ALU_OP     (EX_ALU_OP),
    .EX_REG_DST    (EX_REG_DST),
    .EX_ALU_SRC    (EX_ALU_SRC),
    .EX_MEM_READ   (EX_MEM_READ),
    .EX_MEM_WRITE  (EX_MEM_WRITE),
    .EX_MEM_TO_REG (EX_MEM_TO_REG),
    .EX_REG_WRITE  (EX_REG_WRITE),
    .EX_BRANCH     (EX_BRANCH),
    .EX_BRANCH_NE  (EX_BRANCH_NE)
  );

  always #5 CLK = ~CLK;

  function automatic ex_t mk(input logic [31:0] pc4, input logic [31:0] rs,
                             input logic [31:0] rtd, input logic [31:0] imm,
                             input logic [4:0] rt, input logic [4:0] rd,
                             input logic [2:0] aluop, input logic [7:0] ctl);
    ex_t e;
    e.pc4 = pc4; e.rs = rs; e.rtd = rtd; e.imm = imm;
    e.rt = rt; e.rd = rd; e.aluop = aluop; e.ctl = ctl;
    return e;
  endfunction

  function automatic vec_t mkv(input logic rst_n, input logic flush, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] ins, input logic [31:0] pc4,
                               input ex_t exp);
    vec_t v;
    v.rst_n = rst_n; v.flush = flush; v.we = we; v.wa = wa; v.wd = wd;
    v.ins = ins; v.pc4 = pc4; v.exp = exp;
    return v;
  endfunction

  // Register read as software sees it during decode
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  // What the ID/EX register should hold after this cycle's edge
  function automatic ex_t model_ex(input logic rst_n, input logic flush, input logic we,
                                   input logic [4:0] wa, input logic [31:0] wd,
                                   input logic [31:0] ins, input logic [31:0] pc4);
    ex_t         e;
    logic [5:0]  op;
    logic [15:0] imm16;
    e = '0;
    if (!rst_n || flush) return e;
    op    = ins[31:26];
    imm16 = ins[15:0];
    e.pc4 = pc4;
    e.rs  = model_read(ins[25:21], we, wa, wd);
    e.rtd = model_read(ins[20:16], we, wa, wd);
    e.rt  = ins[20:16];
    e.rd  = ins[15:11];
    if (op == 6'd12 || op == 6'd13) e.imm = 32'(imm16);
    else                            e.imm = 32'($signed(imm16));
    case (op)
      6'd0:  begin e.ctl = C_R;   e.aluop = 3'd2; end
      6'd8:  begin e.ctl = C_I;   e.aluop = 3'd0; end
      6'd12: begin e.ctl = C_I;   e.aluop = 3'd3; end
      6'd13: begin e.ctl = C_I;   e.aluop = 3'd4; end
      6'd10: begin e.ctl = C_I;   e.aluop = 3'd5; end
      6'd35: begin e.ctl = C_LW;  e.aluop = 3'd0; end
      6'd43: begin e.ctl = C_SW;  e.aluop = 3'd0; end
      6'd4:  begin e.ctl = C_BEQ; e.aluop = 3'd1; end
      6'd5:  begin e.ctl = C_BNE; e.aluop = 3'd1; end
      default: begin e.ctl = 8'd0; e.aluop = 3'd0; end
    endcase
    return e;
  endfunction

  // Drive one cycle, predict with the model, advance the model, sample after the edge
  task automatic apply(input logic rst_n, input logic flush, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] ins, input logic [31:0] pc4,
                       output ex_t pred);
    RST_N = rst_n; FLUSH = flush; WB_REG_WRITE = we; WB_WRITE_REG = wa;
    WB_WRITE_DATA = wd; CUR_INS = ins; NEXT_INS_ADR = pc4;
    pred = model_ex(rst_n, flush, we, wa, wd, ins, pc4);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      m_regs[wa] = wd;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int idx, input ex_t exp);
    ex_t act;
    act = {EX_PC4, EX_RS_DATA, EX_RT_DATA, EX_IMM, EX_RT, EX_RD, EX_ALU_OP,
           EX_REG_DST, EX_ALU_SRC, EX_MEM_READ, EX_MEM_WRITE,
           EX_MEM_TO_REG, EX_REG_WRITE, EX_BRANCH, EX_BRANCH_NE};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  vec_t        vecs [16];
  ex_t         pred;
  logic [31:0] same_rw;
  logic [5:0]  ops [10];

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hBAD0_0000;
`ifdef WB_BYPASS_EN
    same_rw = 32'hA5A5_A5A5;
`else
    same_rw = 32'h0000_0000;
`endif
    vecs[0]  = mkv(1'b0, 1'b0, 1'b0, 5'd0,  32'd0, 32'h8C090004, 32'h04, '0);
    vecs[1]  = mkv(1'b0, 1'b0, 1'b0, 5'd0,  32'd0, 32'h8C090004, 32'h08, '0);
    vecs[2]  = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h01200020, 32'h08,
                   mk(32'h08, 32'd0, 32'd0, 32'h20, 5'd0, 5'd0, 3'd2, C_R));
    vecs[3]  = mkv(1'b1, 1'b0, 1'b1, 5'd9,  32'h12345678, 32'h00000000, 32'h0C,
                   mk(32'h0C, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd2, C_R));
    vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h2129FFFF, 32'h10,
                   mk(32'h10, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 5'd9, 5'd31, 3'd0, C_I));
    vecs[5]  = mkv(1'b1, 1'b0, 1'b1, 5'd0,  32'h0000DEAD, 32'h00000000, 32'h14,
                   mk(32'h14, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd2, C_R));
    vecs[6]  = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h3400FFFF, 32'h18,
                   mk(32'h18, 32'd0, 32'd0, 32'h0000FFFF, 5'd0, 5'd31, 3'd4, C_I));
    vecs[7]  = mkv(1'b1, 1'b1, 1'b1, 5'd10, 32'd7, 32'hAD090008, 32'h1C, '0);
    vecs[8]  = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h01400020, 32'h20,
                   mk(32'h20, 32'd7, 32'd0, 32'h20, 5'd0, 5'd0, 3'd2, C_R));
    vecs[9]  = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'hFC000000, 32'h24,
                   mk(32'h24, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 3'd0, 8'd0));
    vecs[10] = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'hFD2A1234, 32'h28,
                   mk(32'h28, 32'h12345678, 32'd7, 32'h1234, 5'd10, 5'd2, 3'd0, 8'd0));
    vecs[11] = mkv(1'b1, 1'b0, 1'b1, 5'd8,  32'hA5A5A5A5, 32'h01000020, 32'h2C,
                   mk(32'h2C, same_rw, 32'd0, 32'h20, 5'd0, 5'd0, 3'd2, C_R));
    vecs[12] = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h11090003, 32'h30,
                   mk(32'h30, 32'hA5A5A5A5, 32'h12345678, 32'd3, 5'd9, 5'd0, 3'd1, C_BEQ));
    vecs[13] = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h8D0AFFFC, 32'h34,
                   mk(32'h34, 32'hA5A5A5A5, 32'd7, 32'hFFFFFFFC, 5'd10, 5'd31, 3'd0, C_LW));
    vecs[14] = mkv(1'b0, 1'b0, 1'b1, 5'd11, 32'd55, 32'h2129FFFF, 32'h38, '0);
    vecs[15] = mkv(1'b1, 1'b0, 1'b0, 5'd0,  32'd0, 32'h2129FFFF, 32'h40,
                   mk(32'h40, 32'd0, 32'd0, 32'hFFFFFFFF, 5'd9, 5'd31, 3'd0, C_I));

    // Directed table: reset, write-then-decode, $0, flush, illegal opcode, same-cycle rw
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].rst_n, vecs[i].flush, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].ins, vecs[i].pc4, pred);
      check("vec", i, vecs[i].exp);
    end

    // Randomized traffic against the behavioural model
    ops[0] = 6'd0;  ops[1] = 6'd8;  ops[2] = 6'd12; ops[3] = 6'd13; ops[4] = 6'd10;
    ops[5] = 6'd35; ops[6] = 6'd43; ops[7] = 6'd4;  ops[8] = 6'd5;  ops[9] = 6'd63;
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_fl, r_we;
      logic [4:0]  r_wa;
      logic [31:0] r_wd, r_ins;
      logic [5:0]  r_op;
      r_rst = ($urandom_range(0, 99) >= 3);
      r_fl  = ($urandom_range(0, 99) < 10);
      r_we  = ($urandom_range(0, 1) == 1);
      r_wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      r_wd  = $urandom;
      if ($urandom_range(0, 3) == 0) r_op = 6'($urandom_range(0, 63));
      else                           r_op = ops[$urandom_range(0, 9)];
      r_ins = {r_op, 26'($urandom)};
      if ($urandom_range(0, 2) == 0) r_ins[25:21] = r_wa;
      if ($urandom_range(0, 3) == 0) r_ins[20:16] = r_wa;
      apply(r_rst, r_fl, r_we, r_wa, r_wd, r_ins, $urandom, pred);
      check("rand", i, pred);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage MIPS pipeline, directly downstream of instruction fetch. It takes the fetched word and PC+4 from fetch and decodes the opcode into control signals. It reads the 32×32 register file, which it owns, and sign- or zero-extends the immediate. All results are registered into the ID/EX pipeline register for the execute stage. It also accepts the write-back port from WB and a flush from branch resolution.

## Interface
Parameters:
- none (widths fixed by the ISA; encodings live in the package)

Ports:
- CLK  in  1  the clock; all state updates on posedge
- RST_N  in  1  synchronous, active-low reset, sampled on posedge CLK
- CUR_INS  in  32  instruction word from fetch
- NEXT_INS_ADR  in  32  PC+4 from fetch
- FLUSH  in  1  squash: load a bubble into ID/EX this edge
- WB_REG_WRITE  in  1  register-file write enable from WB
- WB_WRITE_REG  in  5  write address
- WB_WRITE_DATA  in  32  write data
- EX_PC4  out  32  registered PC+4
- EX_RS_DATA, EX_RT_DATA  out  32 each  registered register reads
- EX_IMM  out  32  registered extended immediate
- EX_RT, EX_RD  out  5 each  registered destination candidates
- EX_ALU_OP  out  3  000 add, 001 sub, 010 R-type/funct, 011 and, 100 or, 101 slt
- EX_REG_DST, EX_ALU_SRC, EX_MEM_READ, EX_MEM_WRITE, EX_MEM_TO_REG, EX_REG_WRITE, EX_BRANCH, EX_BRANCH_NE  out  1 each  registered control

## Operation
- Supported opcodes and their control:
  - R-type 000000: REG_DST=1, ALU_OP=010, REG_WRITE=1.
  - addi 001000: ALU_SRC=1, ALU_OP=000, REG_WRITE=1, sign-extended immediate.
  - andi 001100 / ori 001101: ALU_SRC=1, ALU_OP=011 / 100, REG_WRITE=1, zero-extended immediate.
  - slti 001010: ALU_SRC=1, ALU_OP=101, REG_WRITE=1, sign-extended immediate.
  - lw 100011: ALU_SRC=1, MEM_READ=1, MEM_TO_REG=1, REG_WRITE=1, sign-extended immediate.
  - sw 101011: ALU_SRC=1, MEM_WRITE=1, sign-extended immediate.
  - beq 000100 / bne 000101: ALU_OP=001, BRANCH=1 / BRANCH_NE=1, sign-extended immediate.
- Any other opcode decodes as a bubble: all control 0. Data fields are still latched.
- Immediate extension:
  - Sign extension copies bit 15 into bits 31:16.
  - Zero extension clears bits 31:16.
- Register reads are combinational on CUR_INS[25:21] and CUR_INS[20:16].
- Register $0:
  - Always reads 0.
  - Writes to $0 are discarded.
- A register-file write occurs on posedge when WB_REG_WRITE=1.
- Register-file writes proceed regardless of FLUSH.
- Bubble: all ID/EX outputs load 0.

## Timing
- Latency 1: fields of CUR_INS valid in cycle n appear on EX_* after posedge ending cycle n.
- Reset:
  - RST_N=0 at posedge loads all EX_* outputs with 0.
  - It also clears all 32 registers.
  - Reset has priority over FLUSH and write-back.
  - Reset asserted mid-stream discards the in-flight decode.
- FLUSH=1 at posedge (RST_N=1): ID/EX loads a bubble.
- Same-cycle write/read to the same nonzero register: governed by Configuration.
- Simultaneous FLUSH and write-back: the write commits and ID/EX loads a bubble.
- No stall input: ID/EX advances every cycle.

## Configuration
- WB_BYPASS_EN defined:
  - A read whose address equals WB_WRITE_REG (nonzero) while WB_REG_WRITE=1 returns WB_WRITE_DATA in the same cycle.
  - The EX_*_DATA output therefore carries the new value.
- WB_BYPASS_EN undefined:
  - The read returns the pre-write register contents.
  - Software must place an extra independent instruction between producer write-back and consumer decode.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE;
  - ALU_OP encodings ALU_ADD, ALU_SUB, ALU_FUNCT, ALU_AND, ALU_OR, ALU_SLT.
- Sub-module reg_file:
  - 2 read ports, 1 write port, synchronous reset clear, $0 hardwiring.
  - Contains the WB_BYPASS_EN logic.
- Decode and the ID/EX register stay in id_stage.

## Test plan
- Reset: hold RST_N=0 two cycles with CUR_INS=0x8C090004 -> every EX_* output is 0. After release, reading $9 yields 0.
- Write-then-decode: write $9=0x12345678, then the next cycle CUR_INS=0x2129FFFF (addi $9,$9,-1) -> EX_RS_DATA=0x12345678, EX_IMM=0xFFFFFFFF, EX_ALU_SRC=1, EX_REG_WRITE=1, EX_ALU_OP=000.
- Zero extend and $0: CUR_INS=0x3400FFFF (ori $0,$0,0xFFFF) after a write of 0xDEAD to $0 -> EX_RS_DATA=0, EX_IMM=0x0000FFFF, EX_ALU_OP=100.
- Same-cycle write/read: write $8=0xA5A5A5A5 while CUR_INS reads $8 as rs -> EX_RS_DATA=0xA5A5A5A5 with WB_BYPASS_EN defined, prior value without it.
- FLUSH: CUR_INS=0xAD090008 (sw) with FLUSH=1 and a concurrent write of $10=7 -> EX_MEM_WRITE=0 and all EX_*=0; $10 reads 7 on the next cycle.
- Illegal opcode: CUR_INS=0xFC000000 -> all control outputs 0; EX_PC4 equals NEXT_INS_ADR.
